// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT index generators.
// Optional feature macro used by the datapath blocks: NTT_STAGE_BUBBLE_EN.
package ntt_pkg;

    localparam int unsigned NTT_LOGN_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_DONE   = 2'd3
    } ntt_state_e;

    // Insert a zero at bit position pos: bits below pos stay, bits at/above pos move up one.
    function automatic logic [31:0] insert_zero_bit(input logic [31:0] value, input int unsigned pos);
        logic [31:0] low_mask;
        low_mask = (32'd1 << pos) - 32'd1;
        return ((value & ~low_mask) << 1) | (value & low_mask);
    endfunction

endpackage

// File: rtl/ntt_index_counter_up_counter.sv
// Parameterised wrapping up counter with enable, synchronous active-low clear
// and a terminal-count flag.
module counter_up
    import ntt_pkg::*;
#(
    parameter int unsigned W   = 1,
    parameter int unsigned MAX = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] cnt_q,
    output logic         tc_c
);

    logic [W-1:0] cnt_d;

    // Terminal count and next value: wrap to zero when enabled at MAX.
    always_comb begin
        tc_c  = (cnt_q == W'(MAX));
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ntt_index_counter_up.sv
// Up-counting butterfly index generator for a radix-2 DIT NTT of size 2^LOGN.
// Emits (addr_a, addr_b, twiddle_idx, stage) per butterfly over valid/ready.
// Define NTT_STAGE_BUBBLE_EN to insert one idle cycle between stages.
module ntt_index_counter_up
    import ntt_pkg::*;
#(
    parameter int unsigned LOGN = NTT_LOGN_DEFAULT
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          ready,
    output logic                                          valid,
    output logic [LOGN-1:0]                               addr_a,
    output logic [LOGN-1:0]                               addr_b,
    output logic [((LOGN > 1) ? LOGN - 1 : 1) - 1:0]      twiddle_idx,
    output logic [((LOGN > 1) ? $clog2(LOGN) : 1) - 1:0]  stage,
    output logic                                          busy,
    output logic                                          done
);

    localparam int unsigned AW     = LOGN;
    localparam int unsigned TW     = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int unsigned SW     = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int unsigned BW     = TW;
    localparam int unsigned BF_MAX = (1 << (LOGN - 1)) - 1;
    localparam int unsigned ST_MAX = LOGN - 1;

    ntt_state_e    state_q, state_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [TW-1:0] twiddle_q, twiddle_d;

    logic [BW-1:0] bf_q, bf_nxt_c;
    logic [SW-1:0] stage_q, st_nxt_c;
    logic          bf_tc_c, st_tc_c, st_en_c;
    logic          hs_c, last_c;

    int unsigned   s_c;
    logic [31:0]   low_mask_c;
    logic [31:0]   base_c;

    assign hs_c    = valid_q && ready;
    assign st_en_c = hs_c && bf_tc_c;
    assign last_c  = hs_c && bf_tc_c && st_tc_c;

    // Butterfly index within the stage.
    counter_up #(.W(BW), .MAX(BF_MAX)) u_bf_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (hs_c),
        .cnt_q (bf_q),
        .tc_c  (bf_tc_c)
    );

    // Stage index, advanced by the butterfly counter's terminal count.
    counter_up #(.W(SW), .MAX(ST_MAX)) u_stage_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (st_en_c),
        .cnt_q (stage_q),
        .tc_c  (st_tc_c)
    );

    // Index pair the counters will hold after this edge, used to preload the output tuple.
    always_comb begin
        bf_nxt_c = bf_q;
        st_nxt_c = stage_q;
        if (hs_c) begin
            if (bf_tc_c) begin
                bf_nxt_c = '0;
                st_nxt_c = st_tc_c ? '0 : stage_q + SW'(1);
            end else begin
                bf_nxt_c = bf_q + BW'(1);
            end
        end
    end

    // Control FSM: next state plus valid/busy/done.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (hs_c && bf_tc_c) begin
`ifdef NTT_STAGE_BUBBLE_EN
                    state_d = ST_BUBBLE;
                    valid_d = 1'b0;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_BUBBLE: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Tuple for the next cycle; held while nothing new is presented.
    always_comb begin
        s_c        = 32'(st_nxt_c);
        low_mask_c = (32'd1 << s_c) - 32'd1;
        base_c     = insert_zero_bit(32'(bf_nxt_c), s_c);
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        twiddle_d  = twiddle_q;
        if (valid_d) begin
            addr_a_d  = AW'(base_c);
            addr_b_d  = AW'(base_c | (32'd1 << s_c));
            twiddle_d = TW'((32'(bf_nxt_c) & low_mask_c) << (ST_MAX - s_c));
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            twiddle_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            twiddle_q <= twiddle_d;
        end
    end

    assign valid       = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign addr_a      = addr_a_q;
    assign addr_b      = addr_b_q;
    assign twiddle_idx = twiddle_q;
    assign stage       = stage_q;

endmodule
